// File: rtl/uart_hex_byte_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_hex_byte_parser
// Brief    : Assembles ASCII hex characters from the UART receiver into
//            binary bytes for the two-digit 7-segment display path.
// Revision : 1.0 - initial release
// ============================================================================
module uart_hex_byte_parser #(
  parameter int CLKS_TIMEOUT = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_Byte,
  output logic       o_Byte_DV,
  output logic       o_Pending,
  output logic       o_Error,
  output logic [7:0] o_Error_Count
);

  localparam int                 c_CNT_W = $clog2(CLKS_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_ONE_DIGIT = 1'b1
  } state_t;

  state_t             r_state;
  logic [3:0]         r_hi;
  logic [c_CNT_W-1:0] r_cnt;

  logic       w_is_hex;
  logic       w_is_sep;
  logic [3:0] w_nibble;

  always_comb begin
    w_is_hex = 1'b0;
    w_is_sep = 1'b0;
    w_nibble = 4'h0;
    if (i_RX_Byte >= 8'h30 && i_RX_Byte <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nibble = i_RX_Byte[3:0];
    end else if ((i_RX_Byte >= 8'h41 && i_RX_Byte <= 8'h46) ||
                 (i_RX_Byte >= 8'h61 && i_RX_Byte <= 8'h66)) begin
      // Low nibble of 'A'..'F' / 'a'..'f' is 1..6, so +9 yields 10..15
      w_is_hex = 1'b1;
      w_nibble = i_RX_Byte[3:0] + 4'd9;
    end else if (i_RX_Byte == 8'h0D || i_RX_Byte == 8'h0A || i_RX_Byte == 8'h20) begin
      w_is_sep = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state       <= S_IDLE;
      r_hi          <= 4'h0;
      r_cnt         <= '0;
      o_Byte        <= 8'h00;
      o_Byte_DV     <= 1'b0;
      o_Pending     <= 1'b0;
      o_Error       <= 1'b0;
      o_Error_Count <= 8'h00;
    end else begin
      o_Byte_DV <= 1'b0;
      o_Error   <= 1'b0;
      if (i_RX_DV && !w_is_hex && !(w_is_sep && r_state == S_IDLE) && !w_is_sep) begin
        // Rejected character: drop any held digit, leave o_Byte alone
        o_Error   <= 1'b1;
        r_state   <= S_IDLE;
        o_Pending <= 1'b0;
        if (o_Error_Count != 8'hFF) begin
          o_Error_Count <= o_Error_Count + 8'd1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_RX_DV && w_is_hex) begin
              r_hi      <= w_nibble;
              r_cnt     <= '0;
              r_state   <= S_ONE_DIGIT;
              o_Pending <= 1'b1;
            end
          end
          S_ONE_DIGIT: begin
            if (i_RX_DV) begin
              o_Byte    <= w_is_hex ? {r_hi, w_nibble} : {4'h0, r_hi};
              o_Byte_DV <= 1'b1;
              r_state   <= S_IDLE;
              o_Pending <= 1'b0;
            end else if (r_cnt == c_LAST) begin
              r_state   <= S_IDLE;
              o_Pending <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            o_Pending <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_byte_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_hex_byte_parser
// Brief    : Directed self-checking bench for uart_hex_byte_parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_hex_byte_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] o_byte;
  logic       o_byte_dv;
  logic       o_pending;
  logic       o_error;
  logic [7:0] o_error_count;

  int n_tests = 0;
  int n_fail  = 0;
  int dv_pulses = 0;
  int err_pulses = 0;
  int both_high = 0;

  uart_hex_byte_parser #(.CLKS_TIMEOUT(10)) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_RX_DV      (rx_dv),
    .i_RX_Byte    (rx_byte),
    .o_Byte       (o_byte),
    .o_Byte_DV    (o_byte_dv),
    .o_Pending    (o_pending),
    .o_Error      (o_error),
    .o_Error_Count(o_error_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_byte_dv) dv_pulses++;
      if (o_error) err_pulses++;
      if (o_byte_dv && o_error) both_high++;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_dv = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [11:0] all;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_dv   = (i % 2 == 0);
      rx_byte = 8'h34;
      @(posedge clk);
      #1;
      all = {o_byte, o_byte_dv, o_pending, o_error, |o_error_count};
      n_tests++;
      if (all !== 12'h000) begin n_fail++; $display("FAIL reset_hold: got %h expected 000", all); end
    end
    @(negedge clk);
    rx_dv = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({o_byte, o_byte_dv, o_pending, o_error, o_error_count} !== 20'h0) begin
      n_fail++; $display("FAIL reset_release: byte=%h dv=%b pend=%b err=%b cnt=%h expected all 0",
                         o_byte, o_byte_dv, o_pending, o_error, o_error_count);
    end
  endtask

  task automatic test_two_digit();
    send(8'h34);
    n_tests++;
    if ({o_pending, o_byte_dv} !== 2'b10) begin n_fail++; $display("FAIL two_first_pend: pend,dv=%b expected 10", {o_pending, o_byte_dv}); end
    send(8'h32);
    n_tests++;
    if ({o_byte, o_byte_dv, o_pending} !== {8'h42, 2'b10}) begin n_fail++; $display("FAIL two_commit42: byte=%h dv=%b pend=%b expected 42 1 0", o_byte, o_byte_dv, o_pending); end
    send(8'h66);
    n_tests++;
    if ({o_byte, o_byte_dv, o_pending} !== {8'h42, 2'b01}) begin n_fail++; $display("FAIL two_hold42: byte=%h dv=%b pend=%b expected 42 0 1", o_byte, o_byte_dv, o_pending); end
    send(8'h46);
    n_tests++;
    if ({o_byte, o_byte_dv, o_pending} !== {8'hFF, 2'b10}) begin n_fail++; $display("FAIL two_commitFF: byte=%h dv=%b pend=%b expected ff 1 0", o_byte, o_byte_dv, o_pending); end
    idle(1);
    n_tests++;
    if (o_byte_dv !== 1'b0) begin n_fail++; $display("FAIL two_dv_one_cycle: dv=%b expected 0", o_byte_dv); end
    n_tests++;
    if (dv_pulses != 2) begin n_fail++; $display("FAIL two_dv_count: got %0d expected 2", dv_pulses); end
  endtask

  task automatic test_single_sep();
    int dv0 = dv_pulses;
    send(8'h61);
    send(8'h0D);
    n_tests++;
    if ({o_byte, o_byte_dv, o_pending} !== {8'h0A, 2'b10}) begin n_fail++; $display("FAIL sep_commit0A: byte=%h dv=%b pend=%b expected 0a 1 0", o_byte, o_byte_dv, o_pending); end
    send(8'h20);
    send(8'h0A);
    idle(1);
    n_tests++;
    if ({o_byte, o_pending, o_error_count} !== {8'h0A, 1'b0, 8'h00}) begin n_fail++; $display("FAIL sep_idle_ignored: byte=%h pend=%b cnt=%h expected 0a 0 00", o_byte, o_pending, o_error_count); end
    n_tests++;
    if (dv_pulses - dv0 != 1 || err_pulses != 0) begin n_fail++; $display("FAIL sep_pulses: dv=%0d err=%0d expected 1 0", dv_pulses - dv0, err_pulses); end
  endtask

  task automatic test_reject();
    send(8'h37);
    send(8'h47);
    n_tests++;
    if ({o_error, o_error_count, o_byte, o_pending, o_byte_dv} !== {1'b1, 8'h01, 8'h0A, 2'b00}) begin
      n_fail++; $display("FAIL reject_G: err=%b cnt=%h byte=%h pend=%b dv=%b expected 1 01 0a 0 0", o_error, o_error_count, o_byte, o_pending, o_byte_dv);
    end
    idle(1);
    n_tests++;
    if (o_error !== 1'b0) begin n_fail++; $display("FAIL reject_err_one_cycle: err=%b expected 0", o_error); end
    send(8'h31);
    send(8'h32);
    n_tests++;
    if ({o_byte, o_byte_dv} !== {8'h12, 1'b1}) begin n_fail++; $display("FAIL reject_recover12: byte=%h dv=%b expected 12 1", o_byte, o_byte_dv); end
    idle(1);
  endtask

  task automatic test_timeout();
    int dv0;
    send(8'h35);
    dv0 = dv_pulses;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      n_tests++;
      if (o_pending !== (k < 10)) begin n_fail++; $display("FAIL timeout_pend_k%0d: pend=%b expected %b", k, o_pending, (k < 10)); end
    end
    n_tests++;
    if (dv_pulses != dv0 || o_byte !== 8'h12 || err_pulses != 1) begin
      n_fail++; $display("FAIL timeout_silent: dv=%0d byte=%h err=%0d expected 0 12 1", dv_pulses - dv0, o_byte, err_pulses);
    end
    send(8'h33);
    send(8'h43);
    n_tests++;
    if ({o_byte, o_byte_dv} !== {8'h3C, 1'b1}) begin n_fail++; $display("FAIL timeout_after3C: byte=%h dv=%b expected 3c 1", o_byte, o_byte_dv); end
    send(8'h35);
    idle(9);
    n_tests++;
    if (o_pending !== 1'b1) begin n_fail++; $display("FAIL timeout_edge_pend: pend=%b expected 1", o_pending); end
    send(8'h37);
    n_tests++;
    if ({o_byte, o_byte_dv, o_pending} !== {8'h57, 2'b10}) begin n_fail++; $display("FAIL timeout_strobe_wins: byte=%h dv=%b pend=%b expected 57 1 0", o_byte, o_byte_dv, o_pending); end
    idle(1);
  endtask

  task automatic test_saturation();
    int e0 = err_pulses;
    for (int i = 0; i < 300; i++) begin
      send(8'h7E);
      if (i == 254) begin
        n_tests++;
        if (o_error_count !== 8'hFF) begin n_fail++; $display("FAIL sat_reach255: cnt=%h expected ff", o_error_count); end
      end
    end
    n_tests++;
    if ({o_error, o_error_count} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL sat_hold: err=%b cnt=%h expected 1 ff", o_error, o_error_count); end
    idle(1);
    n_tests++;
    if (err_pulses - e0 != 300 || o_byte !== 8'h57) begin n_fail++; $display("FAIL sat_pulses: got %0d byte=%h expected 300 57", err_pulses - e0, o_byte); end
  endtask

  task automatic test_reset_pending();
    send(8'h39);
    n_tests++;
    if (o_pending !== 1'b1) begin n_fail++; $display("FAIL rstpend_pend: pend=%b expected 1", o_pending); end
    @(negedge clk);
    rx_dv = 1'b0;
    rst   = 1'b1;
    #1;
    n_tests++;
    if ({o_byte, o_byte_dv, o_pending, o_error, o_error_count} !== 20'h0) begin
      n_fail++; $display("FAIL rstpend_async: byte=%h dv=%b pend=%b err=%b cnt=%h expected all 0", o_byte, o_byte_dv, o_pending, o_error, o_error_count);
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'h41);
    n_tests++;
    if ({o_pending, o_byte_dv, o_byte} !== {2'b10, 8'h00}) begin n_fail++; $display("FAIL rstpend_first_idle: pend=%b dv=%b byte=%h expected 1 0 00", o_pending, o_byte_dv, o_byte); end
    send(8'h42);
    n_tests++;
    if ({o_byte, o_byte_dv, o_error_count} !== {8'hAB, 1'b1, 8'h00}) begin n_fail++; $display("FAIL rstpend_AB: byte=%h dv=%b cnt=%h expected ab 1 00", o_byte, o_byte_dv, o_error_count); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_two_digit();
    test_single_sep();
    test_reject();
    test_timeout();
    test_saturation();
    test_reset_pending();
    n_tests++;
    if (both_high != 0) begin n_fail++; $display("FAIL dv_err_exclusive: got %0d overlaps expected 0", both_high); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
